// File: rtl/mf8_pkg.sv
// Shared definitions for the mf8 RAM arbiter: FSM state encoding and master indices.
package mf8_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_ACK  = 2'd2
    } arb_state_e;

    // Master index constants (also used as the grant / last-grant encoding)
    localparam logic ARB_M0 = 1'b0;
    localparam logic ARB_M1 = 1'b1;

endpackage

// File: rtl/mf8_arb_pick.sv
// Two-input grant select for the mf8 RAM arbiter.
// Build option: MF8_ARB_ROUND_ROBIN_EN selects round-robin tie breaking using
// the last-grant pointer; otherwise M0 always wins a tie and no pointer exists.
// The result is only meaningful when at least one request is high.
import mf8_pkg::*;

module mf8_arb_pick (
    input  logic req0,
    input  logic req1,
`ifdef MF8_ARB_ROUND_ROBIN_EN
    input  logic last,
`endif
    output logic gnt
);

    // Select the winning master index
    always_comb begin
        gnt = req0 ? ARB_M0 : ARB_M1;
`ifdef MF8_ARB_ROUND_ROBIN_EN
        // Tie: hand the grant to whichever master did not win last time
        if (req0 && req1) begin
            gnt = (last == ARB_M1) ? ARB_M0 : ARB_M1;
        end
`endif
    end

endmodule

// File: rtl/mf8_ram_arbiter.sv
// mf8_ram_arbiter: shares one single-port data RAM between the mf8 core data
// port (M0) and a secondary master (M1). One access at a time:
// IDLE (arbitrate, latch request) -> BUSY (hold mem_req until mem_ready) ->
// ACK (one-cycle ack to the granted master) -> IDLE.
// Build option: MF8_ARB_ROUND_ROBIN_EN enables round-robin tie breaking.
import mf8_pkg::*;

module mf8_ram_arbiter #(
    parameter int AW = 16,
    parameter int DW = 8
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic [DW-1:0] rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready
);

    arb_state_e    state_q, state_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          m0_ack_q, m0_ack_d;
    logic          m1_ack_q, m1_ack_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          gnt_q, gnt_d;       // master owning the in-flight access
    logic          pick;               // arbitration result for this cycle
`ifdef MF8_ARB_ROUND_ROBIN_EN
    logic          last_q, last_d;     // master granted most recently
`endif

    mf8_arb_pick u_pick (
        .req0 (m0_req),
        .req1 (m1_req),
`ifdef MF8_ARB_ROUND_ROBIN_EN
        .last (last_q),
`endif
        .gnt  (pick)
    );

    // Next-state and datapath: latch winner in IDLE, wait in BUSY, pulse ack in ACK
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        gnt_d       = gnt_q;
        m0_ack_d    = 1'b0;
        m1_ack_d    = 1'b0;
`ifdef MF8_ARB_ROUND_ROBIN_EN
        last_d      = last_q;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (m0_req || m1_req) begin
                    state_d     = ARB_BUSY;
                    gnt_d       = pick;
                    mem_req_d   = 1'b1;
                    mem_we_d    = (pick == ARB_M1) ? m1_we    : m0_we;
                    mem_addr_d  = (pick == ARB_M1) ? m1_addr  : m0_addr;
                    mem_wdata_d = (pick == ARB_M1) ? m1_wdata : m0_wdata;
`ifdef MF8_ARB_ROUND_ROBIN_EN
                    last_d      = pick;
`endif
                end
            end
            ARB_BUSY: begin
                // mem_ready only matters here; stray pulses elsewhere fall through
                if (mem_ready) begin
                    state_d   = ARB_ACK;
                    mem_req_d = 1'b0;
                    if (!mem_we_q) begin
                        rdata_d = mem_rdata;
                    end
                    m0_ack_d = (gnt_q == ARB_M0);
                    m1_ack_d = (gnt_q == ARB_M1);
                end
            end
            ARB_ACK: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d   = ARB_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset; reset abandons any in-flight access
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= ARB_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            gnt_q       <= ARB_M0;
            m0_ack_q    <= 1'b0;
            m1_ack_q    <= 1'b0;
`ifdef MF8_ARB_ROUND_ROBIN_EN
            last_q      <= ARB_M1;
`endif
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            gnt_q       <= gnt_d;
            m0_ack_q    <= m0_ack_d;
            m1_ack_q    <= m1_ack_d;
`ifdef MF8_ARB_ROUND_ROBIN_EN
            last_q      <= last_d;
`endif
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign m0_ack    = m0_ack_q;
    assign m1_ack    = m1_ack_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_mf8_ram_arbiter.sv
// Scoreboard bench for mf8_ram_arbiter: stimulus pushes expected (master, rdata)
// per access; a negedge monitor pops on every ack. Bench also models the RAM.
module tb_mf8_ram_arbiter;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
    logic [15:0] m0_addr = 0, m1_addr = 0;
    logic [7:0]  m0_wdata = 0, m1_wdata = 0;
    logic        m0_ack, m1_ack, mem_req, mem_we;
    logic [7:0]  rdata, mem_wdata;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata = 0;
    logic        mem_ready = 0;

    typedef struct {
        logic       port;
        logic [7:0] data;
    } exp_t;
    exp_t exp_q[$];

    int n_chk = 0;
    int n_fail = 0;
    int wait_cfg = 0;
    int wcnt = 0;
    logic stray = 1'b0;
    logic [7:0] ram [logic [15:0]];

    mf8_ram_arbiter #(.AW(16), .DW(8)) dut (
        .Clk(Clk), .Reset(Reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_ack(m0_ack),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_ack(m1_ack),
        .rdata(rdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // RAM model: answers after wait_cfg extra cycles; stray forces mem_ready with junk data
    always @(negedge Clk) begin
        mem_ready = stray;
        mem_rdata = 8'hEE;
        if (mem_req) begin
            if (wcnt >= wait_cfg) begin
                mem_ready = 1'b1;
                mem_rdata = ram.exists(mem_addr) ? ram[mem_addr] : 8'h00;
                if (mem_we) ram[mem_addr] = mem_wdata;
                wcnt = 0;
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
    end

    // Monitor: every ack must match the next scoreboard entry
    always @(negedge Clk) begin
        if (m0_ack || m1_ack) begin
            n_chk++;
            if (m0_ack && m1_ack) begin
                n_fail++;
                $display("FAIL both_acks: m0_ack=1 m1_ack=1 expected one");
            end else if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_ack: m0=%0b m1=%0b rdata=%0h expected no ack", m0_ack, m1_ack, rdata);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (m1_ack !== e.port || rdata !== e.data) begin
                    n_fail++;
                    $display("FAIL ack_match: got port %0d rdata %0h expected port %0d rdata %0h",
                             m1_ack, rdata, e.port, e.data);
                end
            end
        end
    end

    // Back-to-back read sequence on M0 (req held across accesses)
    task automatic run_m0(input int n, input logic [15:0] base);
        for (int i = 0; i < n; i++) begin
            bit got = 0;
            m0_req = 1'b1; m0_we = 1'b0; m0_addr = base + 16'(i);
            for (int t = 0; t < 60 && !got; t++) begin
                @(negedge Clk);
                got = m0_ack;
            end
            chk("m0_ack_timeout", {31'd0, got}, 32'd1);
        end
        m0_req = 1'b0;
    endtask

    task automatic run_m1(input int n, input logic [15:0] base);
        for (int i = 0; i < n; i++) begin
            bit got = 0;
            m1_req = 1'b1; m1_we = 1'b0; m1_addr = base + 16'(i);
            for (int t = 0; t < 60 && !got; t++) begin
                @(negedge Clk);
                got = m1_ack;
            end
            chk("m1_ack_timeout", {31'd0, got}, 32'd1);
        end
        m1_req = 1'b0;
    endtask

    initial begin
        ram[16'h0012] = 8'hA5;
        ram[16'h0020] = 8'h11; ram[16'h0021] = 8'h12;
        ram[16'h0030] = 8'h21; ram[16'h0031] = 8'h22;
        ram[16'h0001] = 8'hB1; ram[16'h0002] = 8'hB2;
        ram[16'h0003] = 8'hB3; ram[16'h0004] = 8'hB4;
        ram[16'h0040] = 8'h77;

        // Reset values
        repeat (2) @(negedge Clk);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_acks", {m0_ack, m1_ack}, 0);
        chk("rst_rdata", rdata, 0);
        Reset = 1'b0;
        @(negedge Clk);

        // 1: M0 read, zero-wait RAM, exact latency
        exp_q.push_back('{1'b0, 8'hA5});
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h0012;
        chk("t1_no_req_yet", mem_req, 0);
        @(negedge Clk);
        chk("t1_mem_req", mem_req, 1);
        chk("t1_mem_addr", mem_addr, 16'h0012);
        chk("t1_mem_we", mem_we, 0);
        @(negedge Clk);
        chk("t1_m0_ack", m0_ack, 1);
        chk("t1_m1_ack", m1_ack, 0);
        chk("t1_ack_mem_req", mem_req, 0);
        m0_req = 1'b0;
        @(negedge Clk);
        chk("t1_idle_ack", m0_ack, 0);
        @(negedge Clk);
        chk("t1_idle_req", mem_req, 0);

        // 2: M1 write with 3 wait cycles; rdata keeps previous read value
        begin
            int busy = 0;
            bit got = 0;
            wait_cfg = 3;
            exp_q.push_back('{1'b1, 8'hA5});
            m1_req = 1'b1; m1_we = 1'b1; m1_addr = 16'h0100; m1_wdata = 8'h3C;
            for (int t = 0; t < 20 && !got; t++) begin
                @(negedge Clk);
                if (mem_req) begin
                    busy++;
                    chk("t2_mem_we", mem_we, 1);
                    chk("t2_mem_addr", mem_addr, 16'h0100);
                    chk("t2_mem_wdata", mem_wdata, 8'h3C);
                end
                got = m1_ack;
            end
            chk("t2_ack_seen", {31'd0, got}, 1);
            chk("t2_busy_cycles", busy, 4);
            m1_req = 1'b0; m1_we = 1'b0;
            @(negedge Clk);
            chk("t2_single_pulse", m1_ack, 0);
            wait_cfg = 0;
        end
        // Read back the write through M1 (leaves last grant = M1)
        exp_q.push_back('{1'b1, 8'h3C});
        run_m1(1, 16'h0100);
        @(negedge Clk);

        // 3: simultaneous reads, both masters holding req for two accesses each
`ifdef MF8_ARB_ROUND_ROBIN_EN
        exp_q.push_back('{1'b0, 8'h11}); exp_q.push_back('{1'b1, 8'h21});
        exp_q.push_back('{1'b0, 8'h12}); exp_q.push_back('{1'b1, 8'h22});
`else
        exp_q.push_back('{1'b0, 8'h11}); exp_q.push_back('{1'b0, 8'h12});
        exp_q.push_back('{1'b1, 8'h21}); exp_q.push_back('{1'b1, 8'h22});
`endif
        fork
            run_m0(2, 16'h0020);
            run_m1(2, 16'h0030);
        join
        @(negedge Clk);

        // 4: M0 streams 0x0001..0x0004 while M1 wants one read
`ifdef MF8_ARB_ROUND_ROBIN_EN
        exp_q.push_back('{1'b0, 8'hB1}); exp_q.push_back('{1'b1, 8'h77});
        exp_q.push_back('{1'b0, 8'hB2}); exp_q.push_back('{1'b0, 8'hB3});
        exp_q.push_back('{1'b0, 8'hB4});
`else
        exp_q.push_back('{1'b0, 8'hB1}); exp_q.push_back('{1'b0, 8'hB2});
        exp_q.push_back('{1'b0, 8'hB3}); exp_q.push_back('{1'b0, 8'hB4});
        exp_q.push_back('{1'b1, 8'h77});
`endif
        fork
            run_m0(4, 16'h0001);
            run_m1(1, 16'h0040);
        join
        @(negedge Clk);
        chk("t4_rdata_hold", rdata, 8'h77 & 8'hFF
`ifdef MF8_ARB_ROUND_ROBIN_EN
            ^ 8'h77 ^ 8'hB4
`endif
        );

        // 5: reset during BUSY while RAM answers; nothing may be acked
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h0012;
        @(negedge Clk);
        chk("t5_busy", mem_req, 1);
        Reset = 1'b1; stray = 1'b1;
        @(negedge Clk);
        m0_req = 1'b0;
        chk("t5_mem_req", mem_req, 0);
        chk("t5_acks", {m0_ack, m1_ack}, 0);
        chk("t5_rdata", rdata, 0);
        chk("t5_mem_addr", mem_addr, 0);
        @(negedge Clk);
        Reset = 1'b0; stray = 1'b0;
        @(negedge Clk);
        chk("t5_post_acks", {m0_ack, m1_ack}, 0);
        chk("t5_post_req", mem_req, 0);
        @(negedge Clk);
        chk("t5_post_rdata", rdata, 0);

        // 6: stray mem_ready in IDLE and ACK
        stray = 1'b1;
        repeat (3) @(negedge Clk);
        chk("t6_idle_req", mem_req, 0);
        chk("t6_idle_rdata", rdata, 0);
        exp_q.push_back('{1'b0, 8'h12});
        run_m0(1, 16'h0021);
        repeat (3) @(negedge Clk);
        chk("t6_after_req", mem_req, 0);
        chk("t6_after_rdata", rdata, 8'h12);
        stray = 1'b0;

        repeat (3) @(negedge Clk);
        chk("sb_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
